// File: rtl/snax_gemm_csr_manager.sv
// rtl/snax_gemm_csr_manager.sv - CSR front-end for the GEMM accelerator
// Holds the configuration registers, launches them to the shell and returns status reads.
module snax_gemm_csr_manager #(
  parameter int RegRWCount   = 5,
  parameter int RegROCount   = 2,
  parameter int RegDataWidth = 32,
  parameter int RegAddrWidth = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [RegAddrWidth-1:0]            csr_req_addr_i,
  input  logic [RegDataWidth-1:0]            csr_req_data_i,
  input  logic                               csr_req_write_i,
  input  logic                               csr_req_valid_i,
  output logic                               csr_req_ready_o,
  output logic [RegDataWidth-1:0]            csr_rsp_data_o,
  output logic                               csr_rsp_valid_o,
  input  logic                               csr_rsp_ready_i,
  output logic [RegRWCount*RegDataWidth-1:0] csr_reg_set_o,
  output logic                               csr_reg_set_valid_o,
  input  logic                               csr_reg_set_ready_i,
  input  logic [RegROCount*RegDataWidth-1:0] csr_reg_ro_set_i
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LAUNCH = 1'b1;

  localparam logic [RegAddrWidth-1:0] LAUNCH_ADDR = RegAddrWidth'(RegRWCount);

  logic [0:0]              state_q;
  logic [RegDataWidth-1:0] cfg_q [RegRWCount];
  logic [RegDataWidth-1:0] rsp_data_q;
  logic                    rsp_valid_q;

  logic                    addr_is_cfg;
  logic                    addr_is_launch;
  logic                    rsp_held;
  logic                    req_accept;
  logic                    wr_accept;
  logic                    rd_accept;
  logic                    launch_req;
  logic [RegDataWidth-1:0] rd_data;

  assign addr_is_cfg    = csr_req_addr_i < LAUNCH_ADDR;
  assign addr_is_launch = csr_req_addr_i == LAUNCH_ADDR;
  assign rsp_held       = rsp_valid_q && !csr_rsp_ready_i;

  // Writes that could disturb the in-flight configuration wait for the handshake.
  always_comb begin
    csr_req_ready_o = 1'b0;
    if (!rst_i) begin
      if (csr_req_write_i) begin
        csr_req_ready_o = (state_q == ST_IDLE) || !(addr_is_cfg || addr_is_launch);
      end else begin
        csr_req_ready_o = !rsp_held;
      end
    end
  end

  assign req_accept = csr_req_valid_i && csr_req_ready_o;
  assign wr_accept  = req_accept && csr_req_write_i;
  assign rd_accept  = req_accept && !csr_req_write_i;
  assign launch_req = wr_accept && addr_is_launch && csr_req_data_i[0];

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < RegRWCount; i++) begin
      if (csr_req_addr_i == RegAddrWidth'(i)) begin
        rd_data = cfg_q[i];
      end
    end
    if (addr_is_launch) begin
      rd_data = {{(RegDataWidth-1){1'b0}}, state_q == ST_LAUNCH};
    end
    for (int j = 0; j < RegROCount; j++) begin
      if (csr_req_addr_i == RegAddrWidth'(RegRWCount + 1 + j)) begin
        rd_data = csr_reg_ro_set_i[j*RegDataWidth +: RegDataWidth];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (launch_req) state_q <= ST_LAUNCH;
        ST_LAUNCH: if (csr_reg_set_ready_i) state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Config writes are only accepted in IDLE, so the launched words stay frozen.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RegRWCount; i++) begin
        cfg_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RegRWCount; i++) begin
        if (wr_accept && csr_req_addr_i == RegAddrWidth'(i)) begin
          cfg_q[i] <= csr_req_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else if (rd_accept) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= rd_data;
    end else if (csr_rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  for (genvar g = 0; g < RegRWCount; g++) begin : gen_set
    assign csr_reg_set_o[g*RegDataWidth +: RegDataWidth] = cfg_q[g];
  end

  assign csr_reg_set_valid_o = state_q == ST_LAUNCH;
  assign csr_rsp_data_o      = rsp_data_q;
  assign csr_rsp_valid_o     = rsp_valid_q;

endmodule

// File: tb/tb_snax_gemm_csr_manager.sv
// tb/tb_snax_gemm_csr_manager.sv - scoreboard bench for snax_gemm_csr_manager
module tb_snax_gemm_csr_manager;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  req_addr = '0;
  logic [31:0]  req_data = '0;
  logic         req_write = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  rsp_data;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [159:0] set_o;
  logic         set_valid;
  logic         set_ready = 1'b1;
  logic [63:0]  ro_set = '0;

  int tests = 0;
  int fails = 0;
  int rx_count = 0;
  int stall_seen = 0;
  logic acc_rd = 1'b0;
  logic [31:0] exp_q[$];

  snax_gemm_csr_manager dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .csr_req_addr_i      (req_addr),
    .csr_req_data_i      (req_data),
    .csr_req_write_i     (req_write),
    .csr_req_valid_i     (req_valid),
    .csr_req_ready_o     (req_ready),
    .csr_rsp_data_o      (rsp_data),
    .csr_rsp_valid_o     (rsp_valid),
    .csr_rsp_ready_i     (rsp_ready),
    .csr_reg_set_o       (set_o),
    .csr_reg_set_valid_o (set_valid),
    .csr_reg_set_ready_i (set_ready),
    .csr_reg_ro_set_i    (ro_set)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for acceptance; reads push their expected data.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp);
    int cnt = 0;
    req_write = wr;
    req_addr  = addr;
    req_data  = data;
    req_valid = 1'b1;
    if (!wr) exp_q.push_back(exp);
    forever begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        break;
      end
      cnt++;
      if (cnt > 50) begin
        tests++;
        fails++;
        $display("FAIL req_timeout: addr %0d not accepted, required accept within 50 cycles", addr);
        req_valid = 1'b0;
        break;
      end
    end
  endtask

  always @(posedge clk) acc_rd <= !rst && req_valid && req_ready && !req_write;

  // Monitor: compare every consumed response against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (acc_rd) check("rsp_latency", rsp_valid, 1);
      if (rsp_valid && !rsp_ready && req_valid && !req_write) begin
        stall_seen++;
        check("rd_held_stall", req_ready, 0);
      end
      if (rsp_valid && rsp_ready) begin
        rx_count++;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", rsp_data, 160'hDEAD_BEEF_0BAD);
        end else begin
          check("rsp_data", rsp_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0;
    @(negedge clk);
    check("ready_in_reset", req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", req_ready, 1);
    check("reset_set_valid", set_valid, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_cfg", set_o, 0);
    @(posedge clk); #1;

    // Configuration and launch
    do_req(1, 0, 32'd4, 0);
    @(negedge clk);
    check("cfg0_t1", set_o[31:0], 32'd4);
    @(posedge clk); #1;
    do_req(1, 1, 32'd2, 0);
    do_req(1, 2, 32'd8, 0);
    do_req(1, 3, 32'h80, 0);
    @(negedge clk);
    check("cfg_all", set_o, {32'd0, 32'h80, 32'd8, 32'd2, 32'd4});
    @(posedge clk); #1;
    set_ready = 1'b1;
    do_req(1, 5, 32'd1, 0);
    @(negedge clk);
    check("launch_valid_rise", set_valid, 1);
    @(negedge clk);
    check("launch_valid_drop", set_valid, 0);
    @(posedge clk); #1;

    // Launch backpressure
    set_ready = 1'b0;
    do_req(1, 5, 32'd1, 0);
    do_req(0, 5, 0, 32'd1);
    req_write = 1'b1;
    req_addr  = 0;
    req_data  = 32'hFFFF;
    req_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("stall_valid", set_valid, 1);
      check("stall_cfg0", set_o[31:0], 32'd4);
      check("stall_wr_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    set_ready = 1'b1;
    do_req(1, 0, 32'hFFFF, 0);
    @(negedge clk);
    check("stall_released", set_valid, 0);
    @(posedge clk); #1;
    do_req(0, 0, 0, 32'hFFFF);

    // Status readback
    ro_set = {32'h1234, 32'h1};
    do_req(0, 6, 0, 32'h1);
    do_req(0, 7, 0, 32'h1234);
    repeat (2) @(posedge clk);
    #1;

    // Response backpressure with back-to-back reads
    rx0 = rx_count;
    stall_seen = 0;
    fork
      begin
        do_req(0, 0, 0, 32'hFFFF);
        do_req(0, 1, 0, 32'd2);
        do_req(0, 2, 0, 32'd8);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          rsp_ready = (k % 2 == 1);
          @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("bp_rx_count", rx_count - rx0, 3);
    check("bp_stall_seen", stall_seen > 0, 1);
    check("bp_queue_empty", exp_q.size(), 0);

    // Unmapped access and launch bit0 = 0
    do_req(1, 20, 32'hDEAD, 0);
    do_req(1, 6, 32'h5555, 0);
    do_req(0, 20, 0, 32'd0);
    do_req(1, 5, 32'd0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("launch_bit0_zero", set_valid, 0);
    end
    @(posedge clk); #1;
    do_req(0, 6, 0, 32'h1);

    // Reset mid-LAUNCH
    repeat (2) @(posedge clk);
    #1;
    set_ready = 1'b0;
    do_req(1, 5, 32'd1, 0);
    @(negedge clk);
    check("pre_reset_valid", set_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_ready", req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_valid", set_valid, 0);
    check("post_reset_cfg", set_o, 0);
    check("post_reset_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    set_ready = 1'b1;
    for (int a = 0; a < 5; a++) do_req(0, a, 0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
